// File: rtl/manchester_deserializer.sv
// Manchester receive path: finds frames by the "1,1" start-delimiter violation,
// decodes 16 data chips into one byte, and offers it on an AXI4-Stream master
// through a one-entry holding register. Line-code errors and dropped bytes are
// flagged rather than corrected.
module manchester_deserializer #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 serial_in,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 code_error,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_chipCnt;
    logic                 r_firstChip;
    logic [7:0]           r_shift;
    logic [7:0]           r_tdata;
    logic                 r_tvalid;
    logic                 r_codeError;
    logic                 r_overflow;
    logic [ERR_CNT_W-1:0] r_errCount;

    logic                 w_pairValid;
    logic                 w_violation;
    logic                 w_wordDone;
    logic                 w_handshake;
    logic [7:0]           w_byte;

    // A legal data pair always has two different chips; the decoded bit is the first chip.
    assign w_pairValid = r_firstChip ^ serial_in;

    // Violations are an isolated start chip, or an equal-chip pair closing in DATA.
    assign w_violation = ((r_state == START) && !serial_in) ||
                         ((r_state == DATA) && r_chipCnt[0] && !w_pairValid);

    // The byte completes on the edge that samples data chip 15 with a legal pair.
    assign w_wordDone  = (r_state == DATA) && (r_chipCnt == 4'd15) && w_pairValid;
    assign w_byte      = {r_shift[6:0], r_firstChip};
    assign w_handshake = r_tvalid && m_axis_tready;

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign code_error    = r_codeError;
    assign overflow      = r_overflow;
    assign err_count     = r_errCount;

    // Frame FSM: delimiter detection, chip pairing and MSB-first bit shifting.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_chipCnt   <= 4'd0;
            r_firstChip <= 1'b0;
            r_shift     <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (serial_in) begin
                        r_state <= START;
                    end
                end
                START: begin
                    r_chipCnt <= 4'd0;
                    if (serial_in) begin
                        r_state <= DATA;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DATA: begin
                    if (!r_chipCnt[0]) begin
                        r_firstChip <= serial_in;
                        r_chipCnt   <= r_chipCnt + 4'd1;
                    end else if (!w_pairValid) begin
                        r_state   <= IDLE;
                        r_chipCnt <= 4'd0;
                    end else begin
                        r_shift <= w_byte;
                        if (r_chipCnt == 4'd15) begin
                            r_state   <= IDLE;
                            r_chipCnt <= 4'd0;
                        end else begin
                            r_chipCnt <= r_chipCnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_chipCnt <= 4'd0;
                end
            endcase
        end
    end

    // Holding register, error pulse, saturating error counter and sticky overflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata     <= 8'h00;
            r_tvalid    <= 1'b0;
            r_codeError <= 1'b0;
            r_overflow  <= 1'b0;
            r_errCount  <= '0;
        end else begin
            r_codeError <= w_violation;
            if (w_violation && !(&r_errCount)) begin
                r_errCount <= r_errCount + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_wordDone) begin
                if (!r_tvalid || w_handshake) begin
                    r_tdata  <= w_byte;
                    r_tvalid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_handshake) begin
                r_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_manchester_deserializer.sv
// Directed testbench for manchester_deserializer: single byte, back-to-back
// frames, backpressure/overflow, handshake coincidence, violations with counter
// saturation, and reset in the middle of a frame.
module tb_manchester_deserializer;

    localparam int ERR_W = 8;

    logic             aclk;
    logic             aresetn;
    logic             serial_in;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             code_error;
    logic             overflow;
    logic [ERR_W-1:0] err_count;

    int checkCount;
    int failCount;
    int cycleCnt;
    int errPulses;
    int pulseMark;
    logic [7:0] rxQ[$];
    int         rxCycle[$];

    manchester_deserializer #(.ERR_CNT_W(ERR_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .serial_in     (serial_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .code_error    (code_error),
        .overflow      (overflow),
        .err_count     (err_count)
    );

    // 100 MHz chip clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Free-running cycle counter used to measure byte spacing.
    always @(posedge aclk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Monitor on the falling edge: records accepted bytes and counts error pulses.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                rxQ.push_back(m_axis_tdata);
                rxCycle.push_back(cycleCnt);
            end
            if (code_error) begin
                errPulses = errPulses + 1;
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one chip just after a rising edge; the next rising edge samples it.
    task automatic driveChip(input logic c);
        @(posedge aclk);
        #2;
        serial_in = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            driveChip(1'b0);
        end
    endtask

    // Send one full frame: delimiter 1,1 then eight MSB-first Manchester bits.
    task automatic applyStimulus(input logic [7:0] b);
        driveChip(1'b1);
        driveChip(1'b1);
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) begin
                driveChip(1'b1);
                driveChip(1'b0);
            end else begin
                driveChip(1'b0);
                driveChip(1'b1);
            end
        end
    endtask

    task automatic violation();
        driveChip(1'b1);
        driveChip(1'b0);
    endtask

    task automatic doReset();
        #2;
        aresetn   = 1'b0;
        serial_in = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
    endtask

    task automatic clearRx();
        rxQ.delete();
        rxCycle.delete();
    endtask

    initial begin
        checkCount    = 0;
        failCount     = 0;
        cycleCnt      = 0;
        errPulses     = 0;
        aresetn       = 1'b0;
        serial_in     = 1'b0;
        m_axis_tready = 1'b0;
        doReset();

        // Reset values.
        checkOutput("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        checkOutput("rst_tdata", {24'd0, m_axis_tdata}, 32'h00);
        checkOutput("rst_code_error", {31'd0, code_error}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);

        // Single byte 0xA5: valid one cycle after the last chip, for one cycle.
        $display("[TB] single byte");
        m_axis_tready = 1'b1;
        idle(3);
        applyStimulus(8'hA5);
        checkOutput("a5_not_early", {31'd0, m_axis_tvalid}, 32'd0);
        idle(1);
        checkOutput("a5_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        checkOutput("a5_tdata", {24'd0, m_axis_tdata}, 32'hA5);
        idle(1);
        checkOutput("a5_one_cycle", {31'd0, m_axis_tvalid}, 32'd0);
        checkOutput("a5_rx_count", rxQ.size(), 32'd1);

        // Back-to-back frames with no idle gap.
        $display("[TB] back-to-back");
        clearRx();
        pulseMark = errPulses;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        idle(3);
        checkOutput("b2b_count", rxQ.size(), 32'd3);
        if (rxQ.size() == 3) begin
            checkOutput("b2b_byte0", {24'd0, rxQ[0]}, 32'h00);
            checkOutput("b2b_byte1", {24'd0, rxQ[1]}, 32'hFF);
            checkOutput("b2b_byte2", {24'd0, rxQ[2]}, 32'h3C);
            checkOutput("b2b_gap01", rxCycle[1] - rxCycle[0], 32'd18);
            checkOutput("b2b_gap12", rxCycle[2] - rxCycle[1], 32'd18);
        end
        checkOutput("b2b_no_err", errPulses - pulseMark, 32'd0);
        checkOutput("b2b_no_ovf", {31'd0, overflow}, 32'd0);

        // Backpressure across two frames: first byte held, second dropped.
        $display("[TB] backpressure");
        clearRx();
        m_axis_tready = 1'b0;
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        idle(2);
        checkOutput("bp_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        checkOutput("bp_tdata_held", {24'd0, m_axis_tdata}, 32'h12);
        checkOutput("bp_overflow", {31'd0, overflow}, 32'd1);
        m_axis_tready = 1'b1;
        idle(1);
        idle(1);
        checkOutput("bp_drained", {31'd0, m_axis_tvalid}, 32'd0);
        checkOutput("bp_rx_count", rxQ.size(), 32'd1);
        if (rxQ.size() == 1) begin
            checkOutput("bp_rx_byte", {24'd0, rxQ[0]}, 32'h12);
        end
        checkOutput("bp_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Handshake in the exact cycle of the second frame's completion.
        $display("[TB] handshake coincidence");
        doReset();
        checkOutput("hs_ovf_cleared", {31'd0, overflow}, 32'd0);
        clearRx();
        m_axis_tready = 1'b0;
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        m_axis_tready = 1'b1;
        idle(1);
        m_axis_tready = 1'b0;
        checkOutput("hs_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        checkOutput("hs_tdata", {24'd0, m_axis_tdata}, 32'h34);
        checkOutput("hs_no_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("hs_rx_first", rxQ.size(), 32'd1);
        m_axis_tready = 1'b1;
        idle(2);
        checkOutput("hs_rx_count", rxQ.size(), 32'd2);
        if (rxQ.size() == 2) begin
            checkOutput("hs_rx0", {24'd0, rxQ[0]}, 32'h12);
            checkOutput("hs_rx1", {24'd0, rxQ[1]}, 32'h34);
        end

        // Violations: lone 1 chip, bad pair, then saturation of the counter.
        $display("[TB] violations");
        doReset();
        clearRx();
        m_axis_tready = 1'b1;
        idle(2);
        pulseMark = errPulses;
        violation();
        idle(1);
        checkOutput("lone_code_error", {31'd0, code_error}, 32'd1);
        checkOutput("lone_err_count", {24'd0, err_count}, 32'd1);
        idle(1);
        checkOutput("lone_pulse_width", {31'd0, code_error}, 32'd0);
        checkOutput("lone_pulses", errPulses - pulseMark, 32'd1);

        driveChip(1'b1);
        driveChip(1'b1);
        driveChip(1'b1);
        driveChip(1'b0);
        driveChip(1'b0);
        driveChip(1'b1);
        driveChip(1'b1);
        driveChip(1'b1);
        idle(1);
        checkOutput("pair_code_error", {31'd0, code_error}, 32'd1);
        idle(20);
        checkOutput("pair_err_count", {24'd0, err_count}, 32'd2);
        checkOutput("pair_no_byte", rxQ.size(), 32'd0);
        checkOutput("pair_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

        pulseMark = errPulses;
        for (int i = 0; i < (1 << ERR_W) - 3; i++) begin
            violation();
        end
        idle(2);
        checkOutput("sat_reach", {24'd0, err_count}, 32'd255);
        for (int i = 0; i < 6; i++) begin
            violation();
        end
        idle(2);
        checkOutput("sat_hold", {24'd0, err_count}, 32'd255);
        checkOutput("sat_pulses", errPulses - pulseMark, 32'd259);

        // Reset in the middle of a frame with non-reset output state present.
        $display("[TB] reset mid-frame");
        doReset();
        clearRx();
        m_axis_tready = 1'b0;
        applyStimulus(8'h77);
        idle(1);
        violation();
        idle(1);
        checkOutput("pre_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        checkOutput("pre_rst_err", {24'd0, err_count}, 32'd1);
        driveChip(1'b1);
        driveChip(1'b1);
        for (int i = 0; i < 7; i++) begin
            driveChip(i[0] ? 1'b0 : 1'b1);
        end
        aresetn   = 1'b0;
        serial_in = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        checkOutput("mid_rst_tdata", {24'd0, m_axis_tdata}, 32'h00);
        checkOutput("mid_rst_err", {24'd0, err_count}, 32'd0);
        checkOutput("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("mid_rst_code_error", {31'd0, code_error}, 32'd0);
        @(posedge aclk);
        #2;
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        pulseMark     = errPulses;
        idle(2);
        applyStimulus(8'h5A);
        idle(3);
        checkOutput("post_rst_count", rxQ.size(), 32'd1);
        if (rxQ.size() == 1) begin
            checkOutput("post_rst_byte", {24'd0, rxQ[0]}, 32'h5A);
        end
        checkOutput("post_rst_no_err", errPulses - pulseMark, 32'd0);
        checkOutput("post_rst_err_count", {24'd0, err_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
